// File: rtl/rr_producer_arbiter.sv
// Round-robin arbiter: one downstream req/ack channel shared by num_inputs producers; optional slot skip via ARB_TIMEOUT_EN.
// Latency: dst_ack is registered 2 cycles after dst_req is sampled with a zero-stall producer; best case is one word per 4 cycles.
// Backpressure: a stalled producer holds FETCH (skipped after `timeout` cycles with ARB_TIMEOUT_EN); downstream paces via dst_req.
module rr_producer_arbiter #(
    parameter int num_inputs = 4,
    parameter int data_width = 32,
    parameter int timeout    = 15,
    localparam int gw        = $clog2(num_inputs)
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [num_inputs-1:0]            src_req,
    input  logic [num_inputs-1:0]            src_ack,
    input  logic [data_width*num_inputs-1:0] src_din,
    input  logic                             dst_req,
    output logic                             dst_ack,
    output logic [data_width-1:0]            dst_dout,
    output logic [gw-1:0]                    grant_id,
    output logic [31:0]                      xfer_count,
    output logic [15:0]                      skip_count
);

    if (num_inputs < 2 || num_inputs > 16 || timeout < 1 || timeout > 255) begin : g_bad_cfg
        $error("rr_producer_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, FETCH, COOL} state_t;

    state_t                  state, state_nxt;
    logic [num_inputs-1:0]   src_req_nxt, grant_oh;
    logic                    dst_ack_nxt, sel_ack;
    logic [data_width-1:0]   dst_dout_nxt, sel_dat;
    logic [gw-1:0]           grant_id_nxt, grant_inc;
    logic [31:0]             xfer_count_nxt;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]              tmo_cnt, tmo_cnt_nxt;
    logic [15:0]             skip_count_nxt;
    logic                    tmo_hit;
`endif

    // Only the granted producer's ack and data are ever looked at.
    always_comb begin
        sel_dat  = '0;
        sel_ack  = 1'b0;
        grant_oh = '0;
        for (int i = 0; i < num_inputs; i++) begin
            if (grant_id == gw'(i)) begin
                sel_dat     = src_din[i*data_width +: data_width];
                sel_ack     = src_ack[i];
                grant_oh[i] = 1'b1;
            end
        end
    end

    assign grant_inc = (grant_id == gw'(num_inputs - 1)) ? '0 : grant_id + gw'(1);

`ifdef ARB_TIMEOUT_EN
    assign tmo_hit = ({1'b0, tmo_cnt} + 9'd1) >= 9'(timeout);
`endif

    always_comb begin
        state_nxt      = state;
        src_req_nxt    = src_req;
        dst_ack_nxt    = 1'b0;
        dst_dout_nxt   = dst_dout;
        grant_id_nxt   = grant_id;
        xfer_count_nxt = xfer_count;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_nxt    = tmo_cnt;
        skip_count_nxt = skip_count;
`endif
        case (state)
            IDLE: begin
                if (dst_req) begin
                    src_req_nxt = grant_oh;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_nxt = '0;
`endif
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                // An ack in the expiry cycle still wins over the skip.
                if (sel_ack) begin
                    dst_dout_nxt   = sel_dat;
                    dst_ack_nxt    = 1'b1;
                    src_req_nxt    = '0;
                    xfer_count_nxt = xfer_count + 32'd1;
                    grant_id_nxt   = grant_inc;
                    state_nxt      = COOL;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    src_req_nxt  = '0;
                    grant_id_nxt = grant_inc;
                    if (skip_count != 16'hFFFF) begin
                        skip_count_nxt = skip_count + 16'd1;
                    end
                    state_nxt    = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
`endif
            end
            COOL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            src_req    <= '0;
            dst_ack    <= 1'b0;
            dst_dout   <= '0;
            grant_id   <= '0;
            xfer_count <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            skip_count <= '0;
`endif
        end else begin
            state      <= state_nxt;
            src_req    <= src_req_nxt;
            dst_ack    <= dst_ack_nxt;
            dst_dout   <= dst_dout_nxt;
            grant_id   <= grant_id_nxt;
            xfer_count <= xfer_count_nxt;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt    <= tmo_cnt_nxt;
            skip_count <= skip_count_nxt;
`endif
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign skip_count = '0;
`endif

endmodule

// File: tb/tb_rr_producer_arbiter.sv
// Bench for rr_producer_arbiter: 4-input instance with stallable producers and a 3-input instance (timeout 3).
module tb_rr_producer_arbiter;
    localparam int n = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic [3:0]   src_req, src_ack, spur;
    logic [3:0]   p_ack = '0;
    logic [127:0] src_din;
    logic         dst_req, dst_ack;
    logic [31:0]  dst_dout, xfer_count;
    logic [1:0]   grant_id;
    logic [15:0]  skip_count;

    logic [2:0]   src_req3;
    logic [2:0]   p3_ack = '0;
    logic [95:0]  src_din3;
    logic         dst_req3, dst_ack3;
    logic [31:0]  dout3, xfer3;
    logic [1:0]   grant3;
    logic [15:0]  skip3;

    int p_stall[4]  = '{0, 0, 0, 0};
    int p_wait[4]   = '{0, 0, 0, 0};
    int p_seq[4]    = '{0, 0, 0, 0};
    int p3_stall[3] = '{0, 0, 0};
    int p3_wait[3]  = '{0, 0, 0};
    int p3_seq[3]   = '{0, 0, 0};

    assign src_ack = p_ack | spur;

    rr_producer_arbiter #(.num_inputs(4), .data_width(32), .timeout(15)) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_ack(src_ack), .src_din(src_din),
        .dst_req(dst_req), .dst_ack(dst_ack), .dst_dout(dst_dout), .grant_id(grant_id),
        .xfer_count(xfer_count), .skip_count(skip_count)
    );

    rr_producer_arbiter #(.num_inputs(3), .data_width(32), .timeout(3)) dut3 (
        .clk(clk), .rst(rst), .src_req(src_req3), .src_ack(p3_ack), .src_din(src_din3),
        .dst_req(dst_req3), .dst_ack(dst_ack3), .dst_dout(dout3), .grant_id(grant3),
        .xfer_count(xfer3), .skip_count(skip3)
    );

    // Producer word = {producer index, per-producer sequence number}.
    for (genvar g = 0; g < 4; g++) begin : g_din
        assign src_din[g*32 +: 32] = {16'(g), p_seq[g][15:0]};
    end
    for (genvar g = 0; g < 3; g++) begin : g_din3
        assign src_din3[g*32 +: 32] = {16'(g), p3_seq[g][15:0]};
    end

    // Producers answer a request after p_stall idle cycles and drop ack once it is consumed.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (src_req[i] && p_ack[i]) p_seq[i] <= p_seq[i] + 1;
            if (src_req[i] && !p_ack[i]) begin
                if (p_wait[i] >= p_stall[i]) begin
                    p_ack[i]  <= 1'b1;
                    p_wait[i] <= 0;
                end else p_wait[i] <= p_wait[i] + 1;
            end else begin
                p_ack[i]  <= 1'b0;
                p_wait[i] <= 0;
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (src_req3[j] && p3_ack[j]) p3_seq[j] <= p3_seq[j] + 1;
            if (src_req3[j] && !p3_ack[j]) begin
                if (p3_wait[j] >= p3_stall[j]) begin
                    p3_ack[j]  <= 1'b1;
                    p3_wait[j] <= 0;
                end else p3_wait[j] <= p3_wait[j] + 1;
            end else begin
                p3_ack[j]  <= 1'b0;
                p3_wait[j] <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int ack3_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (src_req != 4'b0) check("req_onehot_granted", 64'(src_req), 64'(4'b1 << grant_id));
            check("grant3_below_3", 64'(grant3 < 2'd3), 64'(1));
            if (dst_ack3) ack3_cnt++;
        end
    end

    // Reference model: next slot, per-producer words delivered, transfers, last word forwarded.
    int          m_seq[4] = '{0, 0, 0, 0};
    int          m_slot   = 0;
    int          m_xfer   = 0;
    logic [31:0] m_last   = '0;

    task automatic on_ack();
        int          p;
        logic [31:0] exp;
        p   = m_slot;
        exp = {16'(p), 16'(m_seq[p])};
        check("dout", 64'(dst_dout), 64'(exp));
        check("grant_after_ack", 64'(grant_id), 64'((p + 1) % n));
        m_xfer++;
        check("xfer_count", 64'(xfer_count), 64'(m_xfer));
        check("skip_count", 64'(skip_count), 64'(0));
        m_seq[p]++;
        m_slot = (p + 1) % n;
        m_last = exp;
    endtask

    // Raise dst_req and collect nx words; each ack must land 4+stall cycles after the last (3+stall for the first).
    task automatic run_batch(input int nx, output int total);
        int t0, tprev, p, eg;
        bit got;
        t0      = cyc;
        tprev   = t0;
        dst_req = 1'b1;
        for (int k = 0; k < nx; k++) begin
            p   = m_slot;
            eg  = ((k == 0) ? 3 : 4) + p_stall[p];
            got = 1'b0;
            for (int b = 0; b < 400; b++) begin
                @(negedge clk);
                if (dst_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            check("ack_seen", 64'(got), 64'(1));
            if (!got) break;
            check("ack_gap", 64'(cyc - tprev), 64'(eg));
            on_ack();
            tprev = cyc;
        end
        dst_req = 1'b0;
        total   = cyc - t0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int s0, s1, s2, s3;
        int total;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tot, cnt, a0;
        bit  got;
        tbl[0] = '{0, 0, 0, 0, 15};
        tbl[1] = '{0, 0, 5, 0, 20};
        tbl[2] = '{1, 2, 3, 4, 25};
        tbl[3] = '{2, 0, 0, 1, 18};

        rst = 1'b0; dst_req = 1'b0; dst_req3 = 1'b0; spur = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({src_req, dst_ack, grant_id, skip_count}), 64'(0));
        check("rst_data", 64'({dst_dout, xfer_count}), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Streaming with all producers ready: 8 words, acks 4 cycles apart.
        run_batch(8, tot);
        check("stream8_total", 64'(tot), 64'(31));
        check("stream8_xfer", 64'(xfer_count), 64'(8));

        for (int r = 0; r < 4; r++) begin
            p_stall = '{tbl[r].s0, tbl[r].s1, tbl[r].s2, tbl[r].s3};
            run_batch(4, tot);
            check("tbl_total", 64'(tot), 64'(tbl[r].total));
        end
        p_stall = '{0, 0, 0, 0};

        // Spurious ack while idle.
        spur = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            check("spur_idle_dout", 64'(dst_dout), 64'(m_last));
            check("spur_idle_xfer", 64'(xfer_count), 64'(m_xfer));
            check("spur_idle_ack", 64'(dst_ack), 64'(0));
        end
        spur = '0;

        // Spurious ack on index 3 while index 0 is granted and stalling.
        if (m_slot != 0) run_batch(n - m_slot, tot);
        p_stall[0] = 4;
        dst_req    = 1'b1;
        repeat (2) @(negedge clk);
        spur = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            check("spur_fetch_dout", 64'(dst_dout), 64'(m_last));
            check("spur_fetch_xfer", 64'(xfer_count), 64'(m_xfer));
            check("spur_fetch_ack", 64'(dst_ack), 64'(0));
        end
        spur = '0;
        got  = 1'b0;
        for (int b = 0; b < 50; b++) begin
            @(negedge clk);
            if (dst_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("spur_fetch_ack_seen", 64'(got), 64'(1));
        if (got) on_ack();
        dst_req    = 1'b0;
        p_stall[0] = 0;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) p_stall[i] = int'($urandom_range(0, 6));
            run_batch(int'($urandom_range(1, 7)), tot);
        end
        p_stall = '{0, 0, 0, 0};

        // Asynchronous reset in the middle of a fetch from producer 2.
        if (m_slot != 2) run_batch((2 - m_slot + n) % n, tot);
        p_stall[2] = 100;
        dst_req    = 1'b1;
        got        = 1'b0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            if (src_req[2]) begin
                got = 1'b1;
                break;
            end
        end
        check("fetch2_started", 64'(got), 64'(1));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_ctrl", 64'({src_req, dst_ack, grant_id, skip_count}), 64'(0));
        check("midrst_data", 64'({dst_dout, xfer_count}), 64'(0));
        dst_req    = 1'b0;
        p_stall[2] = 0;
        @(negedge clk);
        rst    = 1'b1;
        m_slot = 0;
        m_xfer = 0;
        m_last = '0;
        @(negedge clk);
        check("post_rst_grant", 64'(grant_id), 64'(0));
        run_batch(1, tot);

        // Three-input instance: slots 0,1,2,0.
        dst_req3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int b = 0; b < 20; b++) begin
                @(negedge clk);
                if (dst_ack3) begin
                    got = 1'b1;
                    break;
                end
            end
            check("n3_ack_seen", 64'(got), 64'(1));
            check("n3_src", 64'(dout3[31:16]), 64'(k % 3));
            check("n3_grant", 64'(grant3), 64'((k + 1) % 3));
        end
        dst_req3 = 1'b0;
        repeat (3) @(negedge clk);
        check("n3_xfer", 64'(xfer3), 64'(4));
`ifdef ARB_TIMEOUT_EN
        // Producer 1 never answers: slot skipped after 3 FETCH cycles, then index 2.
        check("n3_skip_before", 64'(skip3), 64'(0));
        p3_stall[1] = 100000;
        a0          = ack3_cnt;
        dst_req3    = 1'b1;
        got         = 1'b0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            if (src_req3[1]) begin
                got = 1'b1;
                break;
            end
        end
        check("n3_fetch1_started", 64'(got), 64'(1));
        cnt = 0;
        while (src_req3[1] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("n3_timeout_cycles", 64'(cnt), 64'(3));
        check("n3_skip_count", 64'(skip3), 64'(1));
        check("n3_grant_after_skip", 64'(grant3), 64'(2));
        check("n3_no_ack_on_skip", 64'(ack3_cnt), 64'(a0));
        @(negedge clk);
        check("n3_next_req", 64'(src_req3), 64'(3'b100));
        got = 1'b0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            if (dst_ack3) begin
                got = 1'b1;
                break;
            end
        end
        check("n3_after_skip_ack", 64'(got), 64'(1));
        check("n3_after_skip_src", 64'(dout3[31:16]), 64'(2));
        dst_req3 = 1'b0;
        repeat (3) @(negedge clk);
`else
        a0 = ack3_cnt;
        check("n3_skip_tied", 64'(skip3), 64'(0));
        check("n3_acks_counted", 64'(a0), 64'(4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_producer_arbiter.md
# rr_producer_arbiter

Round-robin arbiter that shares one downstream req/ack data channel (typically the `din` port of a generated `arf` graph) among `num_inputs` upstream producers. It uses the four-phase-free req/ack pulse protocol of the dataflow fabric on both sides. When the downstream raises a request, the arbiter fetches one word from the currently selected producer and forwards it with a one-cycle ack. It then advances the grant pointer. It sits between the bench/stream producers and the graph's input operator.

## Interface
- `num_inputs`, 4 — number of upstream producer channels, 2..16.
- `data_width`, 32 — word width.
- `timeout`, 15 — FETCH cycles without producer ack before the slot is skipped (only with the configuration macro), 1..255.
- `clk` input 1 — clock, all state on rising edge.
- `rst` input 1 — reset, asynchronous, active-low.
- `src_req` output num_inputs — request to producer i, registered.
- `src_ack` input num_inputs — one-cycle ack from producer i; data valid in the same cycle.
- `src_din` input data_width*num_inputs — producer i data in slice [data_width*(i+1)-1 : data_width*i].
- `dst_req` input 1 — downstream request, a level held until ack is seen.
- `dst_ack` output 1 — one-cycle ack to downstream, registered.
- `dst_dout` output data_width — forwarded word, registered, stable from the ack cycle until the next capture.
- `grant_id` output clog2(num_inputs) — index of the currently selected producer (round-robin pointer).
- `xfer_count` output 32 — number of completed transfers, wraps at 2^32.
- `skip_count` output 16 — number of timed-out slots, saturates at 0xFFFF.

## Operation
- State machine: IDLE, FETCH, COOL. All outputs are registered.
- Reset (rst=0, asynchronous) forces the following, at any point including mid-FETCH:
  - state=IDLE, `src_req`=0, `dst_ack`=0, `dst_dout`=0, `grant_id`=0, `xfer_count`=0, `skip_count`=0, timeout counter=0.
- IDLE:
  - If `dst_req`=1: set `src_req[grant_id]`<=1, clear the timeout counter, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - On `src_ack[grant_id]`=1:
    - `dst_dout`<=the producer's slice, `dst_ack`<=1, `src_req`<=0.
    - `xfer_count`+1, `grant_id`<=(grant_id+1) mod num_inputs, go to COOL.
  - Otherwise the timeout counter increments.
- COOL:
  - `dst_ack`<=0 and go to IDLE.
  - This state guarantees the downstream has dropped `dst_req` before the arbiter samples it again.
- Grant is strictly round-robin by slot. A slot is consumed on either transfer or skip, never on idle cycles.
- `src_ack` on any index other than `grant_id`, or in any state other than FETCH, is ignored. No capture, no count.
- At most one `src_req` bit is high at any time.
- `dst_req` dropping during FETCH does not abort the fetch. The word is still captured and acked; downstream protocol never does this.
- Wrap: `grant_id` wraps from num_inputs-1 to 0. When num_inputs is not a power of two, the pointer never takes values ≥num_inputs.

## Timing
- `dst_req` sampled high at edge E0 leads to `src_req` high after E0.
- A zero-stall producer acks after E1. The arbiter captures at E2: `dst_ack`=1 and `dst_dout` valid in the cycle after E2.
- After E3 the arbiter is in COOL→IDLE with `dst_ack`=0. The earliest next grant is at E4.
- Best-case throughput: one word per 4 cycles.
- A stalled producer adds one cycle of latency per stall cycle (or triggers a skip, see Configuration).
- `src_req` falls on the same edge that captures the ack. A producer that checks `req & ~ack` therefore never double-acks.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - In FETCH, when the timeout counter reaches `timeout` with no ack on the granted index:
    - `src_req`<=0, `grant_id` advances, `skip_count`+1 (saturating), no `dst_ack`, go to IDLE.
  - An ack arriving in the same cycle as expiry wins: a normal transfer, no skip.
- `ARB_TIMEOUT_EN` undefined:
  - FETCH waits indefinitely, and the timeout counter logic is not built.
  - `skip_count` is tied to 0.

## Test plan
- Reset with all four producers always acking, `dst_req` held high by a consumer model. Required response:
  - 8 transfers; `grant_id` sequence 0,1,2,3,0,1,2,3.
  - Each producer yields values 0,1 in order; `xfer_count`=8.
  - Acks spaced exactly 4 cycles apart.
- Producer 2 stalls 5 cycles, macro off. Required response:
  - The slot-2 transfer's `dst_ack` is delayed by exactly 5 cycles.
  - No other `src_req` is raised meanwhile.
- Producer 1 never acks, macro on, `timeout`=3. Required response:
  - After 3 FETCH cycles `src_req[1]` drops, `skip_count`=1, and the next grant goes to index 2.
  - No `dst_ack` is issued for slot 1.
- Spurious `src_ack[3]` while granting index 0, and while in IDLE. Required response:
  - `dst_dout` unchanged by the spurious ack.
  - `xfer_count` unchanged.
- Assert rst low in the middle of FETCH with `src_req[2]`=1. Required response:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first grant is index 0.
- num_inputs=3. Required response:
  - `grant_id` cycles 0,1,2,0 and never reaches 3.
